mips_dmem_arbiter: RTL

Two-requester arbiter that shares the single-port mips_cpu_data_memory between the mips_cpu_harvard data port (CPU) and a debug/DMA loader port (DMA). Benches use the DMA port to preload and inspect data memory while the CPU runs. The block sequences each access into a one-cycle memory strobe and returns read data after a fixed memory latency. It stalls the losing requester through waitrequest. Only one transaction is outstanding at any time.

---
 rtl/mips_dmem_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mips_dmem_arbiter.sv
// Two-port arbiter sharing the single-port data memory between the CPU data port and a
// debug/DMA loader port; one transaction in flight, fixed read latency.
module mips_dmem_arbiter #(
   parameter int unsigned READ_LATENCY = 1,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,

   input  logic [31:0] cpu_address,
   input  logic        cpu_read,
   input  logic        cpu_write,
   input  logic [31:0] cpu_writedata,
   output logic        cpu_waitrequest,
   output logic        cpu_readvalid,
   output logic [31:0] cpu_readdata,

   input  logic [31:0] dma_address,
   input  logic        dma_read,
   input  logic        dma_write,
   input  logic [31:0] dma_writedata,
   output logic        dma_waitrequest,
   output logic        dma_readvalid,
   output logic [31:0] dma_readdata,

   output logic [31:0] mem_address,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_writedata,
   input  logic [31:0] mem_readdata
);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);
   localparam logic [1:0] LatLast   = 2'(READ_LATENCY - 1);

   state_e      state_q, state_d;
   logic [3:0]  starve_q, starve_d;
   logic [1:0]  lat_q, lat_d;
   logic        owner_q, owner_d;   // 1 = DMA owns the current access
   logic        write_q, write_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] cpu_rdata_q, cpu_rdata_d;
   logic [31:0] dma_rdata_q, dma_rdata_d;

   logic cpu_req, dma_req;
   logic grant_cpu, grant_dma;
   logic idle;

   assign cpu_req = cpu_read | cpu_write;
   assign dma_req = dma_read | dma_write;
   assign idle    = (state_q == StIdle);

   // DMA takes a tie only once it has lost STARVE_LIMIT ties in a row.
   assign grant_dma = dma_req & (~cpu_req | (starve_q == StarveMax));
   assign grant_cpu = cpu_req & ~grant_dma;

   assign cpu_waitrequest = reset | ~(idle & grant_cpu);
   assign dma_waitrequest = reset | ~(idle & grant_dma);

   assign mem_read      = (state_q == StIssue) & ~write_q & ~reset;
   assign mem_write     = (state_q == StIssue) &  write_q & ~reset;
   assign mem_address   = addr_q;
   assign mem_writedata = wdata_q;

   assign cpu_readvalid = (state_q == StResp) & ~owner_q & ~reset;
   assign dma_readvalid = (state_q == StResp) &  owner_q & ~reset;
   assign cpu_readdata  = cpu_rdata_q;
   assign dma_readdata  = dma_rdata_q;

   always_comb begin
      state_d     = state_q;
      starve_d    = starve_q;
      lat_d       = lat_q;
      owner_d     = owner_q;
      write_d     = write_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      cpu_rdata_d = cpu_rdata_q;
      dma_rdata_d = dma_rdata_q;

      unique case (state_q)
         StIdle: begin
            if (cpu_req | dma_req) begin
               state_d = StIssue;
               owner_d = grant_dma;
               // Read and write together is a write.
               write_d = grant_dma ? dma_write     : cpu_write;
               addr_d  = grant_dma ? dma_address   : cpu_address;
               wdata_d = grant_dma ? dma_writedata : cpu_writedata;
               if (grant_dma) begin
                  starve_d = 4'd0;
               end else if (dma_req && (starve_q != StarveMax)) begin
                  starve_d = starve_q + 4'd1;
               end
            end
         end
         StIssue: begin
            lat_d   = 2'd0;
            state_d = write_q ? StIdle : StWait;
         end
         StWait: begin
            if (lat_q == LatLast) begin
               state_d = StResp;
               if (owner_q) begin
                  dma_rdata_d = mem_readdata;
               end else begin
                  cpu_rdata_d = mem_readdata;
               end
            end else begin
               lat_d = lat_q + 2'd1;
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         starve_q    <= 4'd0;
         lat_q       <= 2'd0;
         owner_q     <= 1'b0;
         write_q     <= 1'b0;
         addr_q      <= 32'd0;
         wdata_q     <= 32'd0;
         cpu_rdata_q <= 32'd0;
         dma_rdata_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         starve_q    <= starve_d;
         lat_q       <= lat_d;
         owner_q     <= owner_d;
         write_q     <= write_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cpu_rdata_q <= cpu_rdata_d;
         dma_rdata_q <= dma_rdata_d;
      end
   end

endmodule
